fall_sequencer: RTL

// Central controller for the column of Block row registers in the playfield.
// - Drives the shared 2-bit row state code, the per-row write patterns and the per-row collision vectors.
// - Reads back every row's next/Stop/endgame.
// - Owns the settled-cell field, performs line clears and declares game over.
// - Sits between the piece source/user inputs and the row array; field_out feeds the display path.

---
 rtl/fall_sequencer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/fall_sequencer.sv
// Playfield fall sequencer: drives the shared row-state code and per-row write/collision
// vectors, owns the settled field, clears full lines and declares game over.
module fall_sequencer #(
  parameter int ROWS     = 20,
  parameter int COLS     = 10,
  parameter int TICK_DIV = 25_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 drop,
  input  logic [COLS-1:0]      spawn_pat,
  input  logic [ROWS*COLS-1:0] rows_next,
  input  logic [ROWS-1:0]      stop_in,
  input  logic [ROWS-1:0]      endgame_in,
  output logic [1:0]           row_state,
  output logic [ROWS*COLS-1:0] write_rows,
  output logic [ROWS*COLS-1:0] collision,
  output logic [ROWS*COLS-1:0] field_out,
  output logic [15:0]          lines_cleared,
  output logic                 game_over,
  output logic                 busy
);

  localparam int FW = ROWS * COLS;
  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int IW = (ROWS > 2) ? $clog2(ROWS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [IW-1:0] SCAN_TOP  = IW'(ROWS - 1);

  localparam logic [1:0] RS_CHECK = 2'b00;
  localparam logic [1:0] RS_MOVE  = 2'b01;
  localparam logic [1:0] RS_WSEL  = 2'b10;
  localparam logic [1:0] RS_SHIFT = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_SPAWN     = 4'd1,
    S_SPAWN_CHK = 4'd2,
    S_WAIT      = 4'd3,
    S_MOVE      = 4'd4,
    S_MOVE_CHK  = 4'd5,
    S_MERGE     = 4'd6,
    S_CLEAR     = 4'd7,
    S_SHIFT     = 4'd8,
    S_OVER      = 4'd9
  } state_t;

  state_t          state_r;
  logic [TW-1:0]   tick_r;
  logic [IW-1:0]   scan_r;
  logic [FW-1:0]   settled_r;

  logic            hit_s;
  logic            row_full_s;
  logic [FW-1:0]   shifted_s;
  logic [FW-1:0]   spawn_wr_s;
  logic [FW-1:0]   spawn_col_s;

  assign field_out = settled_r;

  // Landing test: piece rests on a settled cell directly below it, or on the floor
  always_comb begin
    hit_s = |rows_next[(ROWS-1)*COLS +: COLS];
    for (int r = 0; r < ROWS - 1; r++) begin
      hit_s = hit_s | (|(rows_next[r*COLS +: COLS] & settled_r[(r+1)*COLS +: COLS]));
    end
  end

  // Field with the scanned row removed and everything above it dropped by one
  always_comb begin
    row_full_s = &settled_r[int'(scan_r)*COLS +: COLS];
    shifted_s  = settled_r;
    for (int r = 0; r < ROWS; r++) begin
      if (r == 0) begin
        shifted_s[0 +: COLS] = '0;
      end else if (r <= int'(scan_r)) begin
        shifted_s[r*COLS +: COLS] = settled_r[(r-1)*COLS +: COLS];
      end else begin
        shifted_s[r*COLS +: COLS] = settled_r[r*COLS +: COLS];
      end
    end
  end

  // Spawn write pattern and its overlap with the settled top row
  always_comb begin
    spawn_wr_s             = '0;
    spawn_col_s            = '0;
    spawn_wr_s[COLS-1:0]   = spawn_pat;
    spawn_col_s[COLS-1:0]  = spawn_pat & settled_r[COLS-1:0];
  end

  // Sequencer FSM; outputs are loaded on the edge that enters the state they belong to
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= S_IDLE;
      row_state     <= RS_CHECK;
      write_rows    <= '0;
      collision     <= '0;
      settled_r     <= '0;
      lines_cleared <= 16'd0;
      game_over     <= 1'b0;
      busy          <= 1'b0;
      tick_r        <= '0;
      scan_r        <= SCAN_TOP;
    end else begin
      write_rows <= '0;
      collision  <= '0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_r    <= S_SPAWN;
            row_state  <= RS_WSEL;
            busy       <= 1'b1;
            write_rows <= spawn_wr_s;
            collision  <= spawn_col_s;
          end
        end
        S_SPAWN: begin
          state_r   <= S_SPAWN_CHK;
          row_state <= RS_CHECK;
        end
        S_SPAWN_CHK: begin
          if (|endgame_in) begin
            state_r   <= S_OVER;
            busy      <= 1'b0;
            game_over <= 1'b1;
          end else begin
            state_r <= S_WAIT;
            tick_r  <= '0;
          end
        end
        S_WAIT: begin
          // a tick and a drop in the same cycle still give a single step
          if (drop || (tick_r == TICK_LAST)) begin
            state_r   <= S_MOVE;
            row_state <= RS_MOVE;
            tick_r    <= '0;
            if (hit_s) begin
              collision <= rows_next;
            end
          end else begin
            tick_r <= tick_r + TW'(1);
          end
        end
        S_MOVE: begin
          state_r   <= S_MOVE_CHK;
          row_state <= RS_CHECK;
        end
        S_MOVE_CHK: begin
          if (|stop_in) begin
            state_r <= S_MERGE;
          end else begin
            state_r <= S_WAIT;
          end
        end
        S_MERGE: begin
          settled_r <= settled_r | rows_next;
          state_r   <= S_CLEAR;
          row_state <= RS_WSEL;
        end
        S_CLEAR: begin
          state_r   <= S_SHIFT;
          row_state <= RS_SHIFT;
          scan_r    <= SCAN_TOP;
        end
        S_SHIFT: begin
          if (row_full_s) begin
            settled_r     <= shifted_s;
            lines_cleared <= lines_cleared + 16'd1;
          end else if (scan_r == '0) begin
            state_r    <= S_SPAWN;
            row_state  <= RS_WSEL;
            scan_r     <= SCAN_TOP;
            write_rows <= spawn_wr_s;
            collision  <= spawn_col_s;
          end else begin
            scan_r <= scan_r - IW'(1);
          end
        end
        S_OVER: begin
          state_r <= S_OVER;
        end
        default: begin
          state_r   <= S_IDLE;
          row_state <= RS_CHECK;
          busy      <= 1'b0;
          game_over <= 1'b0;
        end
      endcase
    end
  end

endmodule
